// File: rtl/regfile_mp.sv
// Multi-port architectural register file with write-to-read bypass and a per-register busy scoreboard.
// Register 0 is hardwired to zero; register 2 resets to SP_INIT.
module regfile_mp #(
   parameter int unsigned        DWIDTH  = 32,
   parameter int unsigned        NREGS   = 32,
   parameter int unsigned        NREAD   = 2,
   parameter int unsigned        NWRITE  = 1,
   parameter logic [DWIDTH-1:0]  SP_INIT = DWIDTH'(32'h0000_8000),
   parameter bit                 BYPASS  = 1'b1,
   localparam int unsigned       AW      = $clog2(NREGS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NREAD-1:0][AW-1:0]          rs_addr_i,
   output logic [NREAD-1:0][DWIDTH-1:0]      rs_data_o,
   output logic [NREAD-1:0]                  rs_ready_o,
   input  logic [NWRITE-1:0]                 wr_en_i,
   input  logic [NWRITE-1:0][AW-1:0]         wr_addr_i,
   input  logic [NWRITE-1:0][DWIDTH-1:0]     wr_data_i,
   input  logic                              alloc_en_i,
   input  logic [AW-1:0]                     alloc_addr_i,
   input  logic                              flush_i,
   output logic [NREGS-1:0]                  busy_o
);

   logic [NREGS-1:0][DWIDTH-1:0] regs_q, regs_d;
   logic [NREGS-1:0]             busy_q, busy_d;
   logic [NREGS-1:0]             written_c;
   logic [NREGS-1:0]             alloc_c;

   // Write decode: ascending port order lets the highest enabled port win.
   always_comb begin
      written_c = '0;
      regs_d    = regs_q;
      for (int unsigned w = 0; w < NWRITE; w++) begin
         if (wr_en_i[w] && (wr_addr_i[w] != '0)) begin
            written_c[wr_addr_i[w]] = 1'b1;
            regs_d[wr_addr_i[w]]    = wr_data_i[w];
         end
      end
      regs_d[0] = '0;
      if (rst) begin
         regs_d    = '0;
         regs_d[2] = SP_INIT;
      end
   end

   // Scoreboard: a new producer (alloc) outranks a completing one; flush outranks alloc.
   always_comb begin
      alloc_c = '0;
      if (alloc_en_i && (alloc_addr_i != '0)) begin
         alloc_c[alloc_addr_i] = 1'b1;
      end
      busy_d = (busy_q & ~written_c) | alloc_c;
      if (flush_i || rst) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
      busy_q <= busy_d;
   end

   // Read ports: storage, optionally overridden by same-cycle write data.
   always_comb begin
      rs_data_o  = '0;
      rs_ready_o = '1;
      for (int unsigned k = 0; k < NREAD; k++) begin
         rs_data_o[k]  = regs_q[rs_addr_i[k]];
         rs_ready_o[k] = ~busy_q[rs_addr_i[k]];
         if (BYPASS) begin
            for (int unsigned w = 0; w < NWRITE; w++) begin
               if (wr_en_i[w] && (wr_addr_i[w] == rs_addr_i[k])) begin
                  rs_data_o[k] = wr_data_i[w];
               end
            end
            if (written_c[rs_addr_i[k]]) begin
               rs_ready_o[k] = 1'b1;
            end
         end
         if (rs_addr_i[k] == '0) begin
            rs_data_o[k]  = '0;
            rs_ready_o[k] = 1'b1;
         end
      end
   end

   assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a BYPASS=1 and a BYPASS=0 instance share the same stimulus.
module tb_regfile_mp;

   localparam logic [31:0] SP = 32'h0000_8000;

   localparam int K_D0 = 0, K_D1 = 1, K_R0 = 2, K_R1 = 3, K_BUSY = 4;
   localparam int K_ND0 = 5, K_ND1 = 6, K_NR0 = 7, K_NR1 = 8, K_NBUSY = 9;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [1:0][4:0]  rs_addr;
   logic [1:0][31:0] rs_data, nb_data;
   logic [1:0]       rs_ready, nb_ready;
   logic [1:0]       wr_en;
   logic [1:0][4:0]  wr_addr;
   logic [1:0][31:0] wr_data;
   logic             alloc_en;
   logic [4:0]       alloc_addr;
   logic             flush;
   logic [31:0]      busy, nb_busy;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_mp #(.DWIDTH(32), .NREGS(32), .NREAD(2), .NWRITE(2), .SP_INIT(SP), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .rs_addr_i(rs_addr), .rs_data_o(rs_data), .rs_ready_o(rs_ready),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .flush_i(flush), .busy_o(busy)
   );

   regfile_mp #(.DWIDTH(32), .NREGS(32), .NREAD(2), .NWRITE(2), .SP_INIT(SP), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .rs_addr_i(rs_addr), .rs_data_o(nb_data), .rs_ready_o(nb_ready),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .flush_i(flush), .busy_o(nb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic expect_val(input string tag, input int kind, input logic [31:0] v);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = v;
      sb_q.push_back(e);
   endtask

   // Pop everything queued for this cycle and compare at the falling edge.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t        e;
         logic [31:0] got;
         e = sb_q.pop_front();
         case (e.kind)
            K_D0:    got = rs_data[0];
            K_D1:    got = rs_data[1];
            K_R0:    got = 32'(rs_ready[0]);
            K_R1:    got = 32'(rs_ready[1]);
            K_BUSY:  got = busy;
            K_ND0:   got = nb_data[0];
            K_ND1:   got = nb_data[1];
            K_NR0:   got = 32'(nb_ready[0]);
            K_NR1:   got = 32'(nb_ready[1]);
            default: got = nb_busy;
         endcase
         check_eq(e.tag, got, e.exp);
      end
   end

   task automatic idle();
      rst        = 1'b0;
      rs_addr    = '0;
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      alloc_en   = 1'b0;
      alloc_addr = '0;
      flush      = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
      wr_en[port]   = 1'b1;
      wr_addr[port] = a;
      wr_data[port] = d;
   endtask

   task automatic alloc(input logic [4:0] a);
      alloc_en   = 1'b1;
      alloc_addr = a;
   endtask

   initial begin
      idle();
      // Reset cycle with a write and alloc that must be discarded.
      rst = 1'b1;
      wr(0, 5'd5, 32'hAA);
      alloc(5'd5);
      next_cycle();

      rs_addr[0] = 5'd2; rs_addr[1] = 5'd5;
      expect_val("rst_r2", K_D0, SP);
      expect_val("rst_r5", K_D1, 32'h0);
      expect_val("rst_rdy0", K_R0, 32'd1);
      expect_val("rst_rdy1", K_R1, 32'd1);
      expect_val("rst_busy", K_BUSY, 32'h0);
      expect_val("rst_nb_r2", K_ND0, SP);
      expect_val("rst_nb_r5", K_ND1, 32'h0);
      expect_val("rst_nb_rdy0", K_NR0, 32'd1);
      expect_val("rst_nb_rdy1", K_NR1, 32'd1);
      expect_val("rst_nb_busy", K_NBUSY, 32'h0);
      next_cycle();

      wr(0, 5'd7, 32'hDEADBEEF); rs_addr[0] = 5'd7;
      expect_val("byp_r7", K_D0, 32'hDEADBEEF);
      expect_val("nobyp_r7_old", K_ND0, 32'h0);
      next_cycle();

      rs_addr[0] = 5'd7;
      expect_val("hold_r7", K_D0, 32'hDEADBEEF);
      expect_val("nb_hold_r7", K_ND0, 32'hDEADBEEF);
      next_cycle();

      wr(0, 5'd0, 32'h1234); alloc(5'd0); rs_addr[0] = 5'd0;
      expect_val("r0_byp", K_D0, 32'h0);
      expect_val("r0_rdy", K_R0, 32'd1);
      expect_val("nb_r0", K_ND0, 32'h0);
      next_cycle();

      rs_addr[0] = 5'd0;
      expect_val("r0_after", K_D0, 32'h0);
      expect_val("r0_busy", K_BUSY, 32'h0);
      next_cycle();

      wr(0, 5'd9, 32'h11); wr(1, 5'd9, 32'h22); rs_addr[0] = 5'd9;
      expect_val("dual_byp", K_D0, 32'h22);
      next_cycle();

      rs_addr[0] = 5'd9;
      expect_val("dual_store", K_D0, 32'h22);
      expect_val("nb_dual_store", K_ND0, 32'h22);
      next_cycle();

      // Scoreboard on r3.
      alloc(5'd3); rs_addr[0] = 5'd3;
      expect_val("sb_c0_rdy", K_R0, 32'd1);
      next_cycle();
      rs_addr[0] = 5'd3;
      expect_val("sb_c1_busy", K_BUSY, 32'h8);
      expect_val("sb_c1_rdy", K_R0, 32'd0);
      expect_val("sb_c1_nb_rdy", K_NR0, 32'd0);
      next_cycle();
      rs_addr[0] = 5'd3;
      expect_val("sb_c2_rdy", K_R0, 32'd0);
      next_cycle();
      wr(0, 5'd3, 32'h55); rs_addr[0] = 5'd3;
      expect_val("sb_c3_rdy", K_R0, 32'd1);
      expect_val("sb_c3_data", K_D0, 32'h55);
      expect_val("sb_c3_nb_rdy", K_NR0, 32'd0);
      expect_val("sb_c3_nb_data", K_ND0, 32'h0);
      next_cycle();
      rs_addr[0] = 5'd3;
      expect_val("sb_c4_busy", K_BUSY, 32'h0);
      expect_val("sb_c4_rdy", K_R0, 32'd1);
      expect_val("sb_c4_nb_data", K_ND0, 32'h55);
      next_cycle();
      wr(1, 5'd3, 32'h66); alloc(5'd3); rs_addr[1] = 5'd3;
      expect_val("sb_aw_rdy", K_R1, 32'd1);
      expect_val("sb_aw_data", K_D1, 32'h66);
      next_cycle();
      rs_addr[1] = 5'd3;
      expect_val("sb_aw_busy", K_BUSY, 32'h8);
      expect_val("sb_aw_rdy_next", K_R1, 32'd0);
      expect_val("sb_aw_data_next", K_D1, 32'h66);
      next_cycle();

      // Flush overrides a same-cycle alloc; writes still commit.
      alloc(5'd4);
      expect_val("fl_busy0", K_BUSY, 32'h8);
      next_cycle();
      alloc(5'd6);
      expect_val("fl_busy1", K_BUSY, 32'h18);
      next_cycle();
      flush = 1'b1; alloc(5'd8); wr(0, 5'd10, 32'h77);
      expect_val("fl_busy2", K_BUSY, 32'h58);
      next_cycle();
      rs_addr[0] = 5'd10;
      expect_val("fl_busy3", K_BUSY, 32'h0);
      expect_val("fl_nb_busy3", K_NBUSY, 32'h0);
      expect_val("fl_wr_commit", K_D0, 32'h77);
      next_cycle();

      // Reset mid-operation.
      alloc(5'd11);
      next_cycle();
      rst = 1'b1; wr(0, 5'd12, 32'h99); rs_addr[0] = 5'd7;
      expect_val("mrst_pre_busy", K_BUSY, 32'h800);
      expect_val("mrst_pre_r7", K_D0, 32'hDEADBEEF);
      next_cycle();
      rs_addr[0] = 5'd12; rs_addr[1] = 5'd7;
      expect_val("mrst_busy", K_BUSY, 32'h0);
      expect_val("mrst_r12", K_D0, 32'h0);
      expect_val("mrst_r7", K_D1, 32'h0);
      expect_val("mrst_rdy1", K_R1, 32'd1);
      next_cycle();
      rs_addr[1] = 5'd2;
      expect_val("mrst_r2", K_D1, SP);
      expect_val("mrst_nb_r2", K_ND1, SP);
      next_cycle();

      @(negedge clk);
      #1;
      check_eq("sb_drain", 32'(sb_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
